// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-port SDRAM arbiter.
//   - arb_state_t : sequencer states
//   - ARB_ADDR_W  : default byte address width (64 MB)
//   - ARB_TIMEOUT : default watchdog limit in WAIT cycles
//   - ARB_RD_FILL : read data returned when an access times out
//   - pick_port   : round-robin winner selection
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_t;

  localparam int          ARB_ADDR_W  = 26;
  localparam int          ARB_TIMEOUT = 1024;
  localparam logic [7:0]  ARB_RD_FILL = 8'hFF;

  // Returns the winning port (0/1). A lone request wins outright; under
  // contention the port that was not granted last time wins.
  function automatic logic pick_port(input logic p0, input logic p1,
                                     input logic last);
    return (p0 && p1) ? ~last : p1;
  endfunction

endpackage

// File: rtl/sdram_arbiter.sv
// Two-port arbiter/sequencer in front of the single-byte SDRAM controller.
// Port 0 is the CPU path, port 1 a DMA/loader master. One byte access is in
// flight at a time; a watchdog force-completes accesses the controller never
// finishes and latches a sticky err flag.
//
// Ports:
//   clock, reset             system clock, async active-high reset
//   pN_req/we/address/wdata  port N request (held until pN_ack)
//   pN_rdata, pN_ack         port N read data (held) and completion pulse
//   sd_req                   one-cycle start strobe to the controller
//   sd_we/address/wdata      access attributes, stable ISSUE..DONE
//   sd_rdata, sd_ready       controller read data and idle/data-valid
//   grant                    one-hot owner of the current access
//   err                      sticky timeout indicator
import sdram_arbiter_pkg::*;

module sdram_arbiter #(
  parameter int ADDR_W  = ARB_ADDR_W,
  parameter int TIMEOUT = ARB_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_address,
  input  logic [7:0]        p0_wdata,
  output logic [7:0]        p0_rdata,
  output logic              p0_ack,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_address,
  input  logic [7:0]        p1_wdata,
  output logic [7:0]        p1_rdata,
  output logic              p1_ack,
  output logic              sd_req,
  output logic              sd_we,
  output logic [ADDR_W-1:0] sd_address,
  output logic [7:0]        sd_wdata,
  input  logic [7:0]        sd_rdata,
  input  logic              sd_ready,
  output logic [1:0]        grant,
  output logic              err
);

  localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  arb_state_t        state_q, state_d;
  logic              last_q, last_d;    // port granted most recently
  logic              own_q, own_d;      // port owning the access in flight
  logic [1:0]        grant_q, grant_d;
  logic              sd_req_q, sd_req_d;
  logic              sd_we_q, sd_we_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [7:0]        sd_wdata_q, sd_wdata_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              err_q, err_d;
  logic [1:0][7:0]   rdata_q, rdata_d;
  logic [1:0]        ack_q, ack_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      own_q      <= 1'b0;
      grant_q    <= '0;
      sd_req_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      wdog_q     <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      own_q      <= own_d;
      grant_q    <= grant_d;
      sd_req_q   <= sd_req_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      wdog_q     <= wdog_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      ack_q      <= ack_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    own_d      = own_q;
    grant_d    = grant_q;
    sd_req_d   = 1'b0;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    wdog_d     = wdog_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    ack_d      = '0;

    unique case (state_q)
      // Waiting on sd_ready also covers a controller still busy with an
      // access that was cut off by our own reset.
      ST_IDLE: begin
        if (sd_ready && (p0_req || p1_req)) begin
          own_d      = pick_port(p0_req, p1_req, last_q);
          sd_we_d    = own_d ? p1_we      : p0_we;
          sd_addr_d  = own_d ? p1_address : p0_address;
          sd_wdata_d = own_d ? p1_wdata   : p0_wdata;
          grant_d    = own_d ? 2'b10      : 2'b01;
          sd_req_d   = 1'b1;            // visible during ISSUE only
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        wdog_d  = '0;
        state_d = ST_WAIT;
      end
      // First WAIT cycle (wdog==0) ignores sd_ready: the controller only
      // drops it one cycle after the strobe. Ack/rdata are registered here
      // so they appear during DONE.
      ST_WAIT: begin
        if (wdog_q != '0 && sd_ready) begin
          ack_d[own_q] = 1'b1;
          if (!sd_we_q) rdata_d[own_q] = sd_rdata;
          state_d = ST_DONE;
        end else if (wdog_q == WD_LAST) begin
          ack_d[own_q] = 1'b1;
          if (!sd_we_q) rdata_d[own_q] = ARB_RD_FILL;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      ST_DONE: begin
        last_d  = own_q;
        grant_d = '0;
        sd_we_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign p0_rdata   = rdata_q[0];
  assign p1_rdata   = rdata_q[1];
  assign p0_ack     = ack_q[0];
  assign p1_ack     = ack_q[1];
  assign sd_req     = sd_req_q;
  assign sd_we      = sd_we_q;
  assign sd_address = sd_addr_q;
  assign sd_wdata   = sd_wdata_q;
  assign grant      = grant_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;

  localparam int AW = 26;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [AW-1:0] p0_address = '0, p1_address = '0;
  logic [7:0]    p0_wdata = '0, p1_wdata = '0;
  logic [7:0]    p0_rdata, p1_rdata;
  logic          p0_ack, p1_ack;
  logic          sd_req, sd_we;
  logic [AW-1:0] sd_address;
  logic [7:0]    sd_wdata;
  logic [7:0]    sd_rdata = '0;
  logic          sd_ready = 1'b1;
  logic [1:0]    grant;
  logic          err;

  sdram_arbiter #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_address(p0_address), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_address(p1_address), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .sd_req(sd_req), .sd_we(sd_we), .sd_address(sd_address), .sd_wdata(sd_wdata),
    .sd_rdata(sd_rdata), .sd_ready(sd_ready), .grant(grant), .err(err)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- controller model ----------------
  logic [7:0] mem [logic [AW-1:0]];
  int   lat = 0;
  bit   stuck = 0, hold_low = 0, busy = 0;
  int   cnt = 0;
  logic [7:0] rd_pend = '0;

  function automatic logic [7:0] lookup(input logic [AW-1:0] a);
    return mem.exists(a) ? mem[a] : (a[7:0] ^ 8'h5A);
  endfunction

  always @(negedge clock) begin
    if (hold_low) begin
      sd_ready = 1'b0;
      busy = 0;
    end else if (sd_req) begin
      if (sd_we) mem[sd_address] = sd_wdata;
      else rd_pend = lookup(sd_address);
      sd_ready = 1'b0;
      busy = 1;
      cnt = lat;
    end else if (busy) begin
      if (!stuck) begin
        if (cnt == 0) begin
          sd_ready = 1'b1;
          sd_rdata = rd_pend;
          busy = 0;
        end else cnt--;
      end
    end else sd_ready = 1'b1;
  end

  // ---------------- scoreboard ----------------
  typedef struct { logic port; logic [7:0] rdata; } exp_t;
  exp_t sb[$];
  logic [7:0] exp_p0 = '0, exp_p1 = '0;

  always @(negedge clock) begin
    if (!reset && (p0_ack || p1_ack)) begin
      check("ack_overlap", {31'd0, p0_ack & p1_ack}, 32'd0);
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("ack_port", {30'd0, p1_ack, p0_ack}, e.port ? 32'd2 : 32'd1);
        check("ack_rdata", {24'd0, e.port ? p1_rdata : p0_rdata}, {24'd0, e.rdata});
      end
    end
  end

  task automatic wait_sdreq(input int max);
    int n;
    n = 0;
    do begin @(negedge clock); n++; end while (!sd_req && n < max);
    check("wait_sd_req", {31'd0, sd_req}, 32'd1);
  endtask

  task automatic wait_ack(input logic port, input int max, output int n);
    n = 0;
    do begin @(negedge clock); n++; end
    while (!(port ? p1_ack : p0_ack) && n < max);
    check("wait_ack", {31'd0, port ? p1_ack : p0_ack}, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    bit bad;
    // ---- reset values ----
    repeat (2) @(negedge clock);
    check("rst_sd_req", {31'd0, sd_req}, 32'd0);
    check("rst_sd_we", {31'd0, sd_we}, 32'd0);
    check("rst_sd_addr", {6'd0, sd_address}, 32'd0);
    check("rst_sd_wdata", {24'd0, sd_wdata}, 32'd0);
    check("rst_rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
    check("rst_ack", {30'd0, p0_ack, p1_ack}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (2) @(posedge clock);

    // ---- single read, port 0 ----
    mem[26'h0000123] = 8'hA5; lat = 6;
    #1 p0_we = 0; p0_address = 26'h0000123; p0_req = 1;
    sb.push_back('{1'b0, 8'hA5}); exp_p0 = 8'hA5;
    wait_sdreq(20);
    check("t1_grant_issue", {30'd0, grant}, 32'd1);
    check("t1_sd_addr", {6'd0, sd_address}, 32'h123);
    check("t1_sd_we", {31'd0, sd_we}, 32'd0);
    wait_ack(1'b0, 60, n);
    check("t1_grant_done", {30'd0, grant}, 32'd1);
    check("t1_p1_untouched", {23'd0, p1_ack, p1_rdata}, 32'd0);
    @(posedge clock); #1 p0_req = 0;
    @(negedge clock);
    check("t1_ack_single", {31'd0, p0_ack}, 32'd0);
    check("t1_grant_idle", {30'd0, grant}, 32'd0);

    // ---- minimum latency, port 1 read ----
    lat = 0;
    @(posedge clock); #1 p1_we = 0; p1_address = 26'h0000042; p1_req = 1;
    exp_p1 = lookup(26'h0000042); sb.push_back('{1'b1, exp_p1});
    wait_ack(1'b1, 40, n);
    check("t2_min_latency", n, 32'd5);
    @(posedge clock); #1 p1_req = 0;

    // ---- contention: both held, alternate p0,p1,p0,p1 ----
    @(posedge clock); #1
    p0_we = 0; p0_address = 26'h0000010; p1_we = 0; p1_address = 26'h2000020;
    p0_req = 1; p1_req = 1;
    exp_p0 = lookup(26'h0000010); exp_p1 = lookup(26'h2000020);
    for (int k = 0; k < 4; k++) sb.push_back('{logic'(k % 2), (k % 2) ? exp_p1 : exp_p0});
    for (int k = 0; k < 4; k++) begin
      wait_ack(logic'(k % 2), 40, n);
      if (k > 0) check("t3_gap", n, 32'd5);
    end
    @(posedge clock); #1 p0_req = 0; p1_req = 0;
    @(negedge clock);
    check("t3_grant_idle", {30'd0, grant}, 32'd0);
    check("t3_err_clear", {31'd0, err}, 32'd0);

    // ---- port 1 write to top address ----
    lat = 2;
    @(posedge clock); #1 p1_we = 1; p1_address = 26'h3FFFFFF; p1_wdata = 8'h3C; p1_req = 1;
    sb.push_back('{1'b1, exp_p1});
    wait_sdreq(20);
    check("t4_grant", {30'd0, grant}, 32'd2);
    bad = 0; n = 0;
    do begin
      if (!(sd_we === 1'b1 && sd_address === 26'h3FFFFFF && sd_wdata === 8'h3C)) bad = 1;
      @(negedge clock); n++;
    end while (!p1_ack && n < 40);
    if (!(sd_we === 1'b1 && sd_address === 26'h3FFFFFF && sd_wdata === 8'h3C)) bad = 1;
    check("t4_wr_ack", {31'd0, p1_ack}, 32'd1);
    check("t4_wr_stable", {31'd0, bad}, 32'd0);
    @(posedge clock); #1 p1_req = 0; p1_we = 0;
    // read it back through port 0
    @(posedge clock); #1 p0_address = 26'h3FFFFFF; p0_req = 1;
    exp_p0 = 8'h3C; sb.push_back('{1'b0, 8'h3C});
    wait_ack(1'b0, 40, n);
    @(posedge clock); #1 p0_req = 0;

    // ---- watchdog timeout (TIMEOUT=16) ----
    stuck = 1; lat = 0;
    @(posedge clock); #1 p0_address = 26'h0000777; p0_req = 1;
    exp_p0 = 8'hFF; sb.push_back('{1'b0, 8'hFF});
    wait_sdreq(20);
    wait_ack(1'b0, 60, n);
    check("t5_wait_cycles", n, 32'd17);
    check("t5_err", {31'd0, err}, 32'd1);
    @(posedge clock); #1 p0_req = 0; stuck = 0;
    lat = 3;
    @(posedge clock); #1 p1_address = 26'h0000055; p1_req = 1;
    exp_p1 = lookup(26'h0000055); sb.push_back('{1'b1, exp_p1});
    wait_ack(1'b1, 60, n);
    check("t5_err_sticky", {31'd0, err}, 32'd1);
    @(posedge clock); #1 p1_req = 0;

    // ---- reset during WAIT ----
    lat = 50;
    @(posedge clock); #1 p0_address = 26'h0000321; p0_req = 1;
    wait_sdreq(20);
    repeat (3) @(negedge clock);
    @(posedge clock); #1 reset = 1; hold_low = 1;
    @(negedge clock);
    check("t6_rst_sd", {30'd0, sd_req, sd_we}, 32'd0);
    check("t6_rst_grant", {30'd0, grant}, 32'd0);
    check("t6_rst_rdata", {16'd0, p0_rdata, p1_rdata}, 32'd0);
    check("t6_rst_err", {31'd0, err}, 32'd0);
    @(posedge clock); #1 reset = 0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (sd_req !== 1'b0 || p0_ack !== 1'b0 || p1_ack !== 1'b0 || grant !== 2'b00) bad = 1;
    end
    check("t6_hold_idle", {31'd0, bad}, 32'd0);
    lat = 2; hold_low = 0;
    exp_p0 = lookup(26'h0000321); sb.push_back('{1'b0, exp_p0});
    wait_sdreq(20);
    wait_ack(1'b0, 40, n);
    @(posedge clock); #1 p0_req = 0;

    repeat (4) @(negedge clock);
    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
